arvi_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that sits directly downstream of the core's bus masters, typically the instruction fetch port and the data port. It feeds a single bus slave port, such as shared memory or an interconnect.
- Selects one pending master with round-robin priority.
- Registers the selected request and drives it onto the slave bus.
- Routes the slave's ack and read data back to the granted master only.
- A watchdog terminates transactions the slave never acknowledges.

---
 rtl/arvi_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_arvi_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arvi_bus_arbiter.sv
// Two-master, one-slave bus arbiter with round-robin priority and a
// watchdog that terminates slave transactions that never complete.
module arvi_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_bus_en,
    input  logic        i_m0_wr_en,
    input  logic [31:0] i_m0_wr_data,
    input  logic [31:0] i_m0_addr,
    input  logic [3:0]  i_m0_byte_en,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_rd_data,
    input  logic        i_m1_bus_en,
    input  logic        i_m1_wr_en,
    input  logic [31:0] i_m1_wr_data,
    input  logic [31:0] i_m1_addr,
    input  logic [3:0]  i_m1_byte_en,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_rd_data,
    output logic        o_s_bus_en,
    output logic        o_s_wr_en,
    output logic [31:0] o_s_wr_data,
    output logic [31:0] o_s_addr,
    output logic [3:0]  o_s_byte_en,
    input  logic        i_s_ack,
    input  logic [31:0] i_s_rd_data,
    output logic        o_grant,
    output logic        o_timeout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_nxt;
    logic            ptr, ptr_nxt;
    logic            grant_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            s_bus_en_nxt, s_wr_en_nxt;
    logic [31:0]     s_wr_data_nxt, s_addr_nxt;
    logic [3:0]      s_byte_en_nxt;
    logic            sel;
    logic            wd_fire;
    logic            done;
    logic [31:0]     ret_data;

    // Watchdog fires only when the slave stays silent in the last allowed cycle
    assign wd_fire = (TIMEOUT != 0) && (state == BUSY) && !i_s_ack && (count == WD_LAST);
    assign done    = (state == BUSY) && (i_s_ack || wd_fire);

    // Return path: completion and data go only to the granted master
    always_comb begin
        ret_data     = i_s_ack ? i_s_rd_data : ERR_DATA;
        o_m0_ack     = done && (o_grant == 1'b0);
        o_m1_ack     = done && (o_grant == 1'b1);
        o_m0_rd_data = o_m0_ack ? ret_data : 32'h0000_0000;
        o_m1_rd_data = o_m1_ack ? ret_data : 32'h0000_0000;
        o_timeout    = wd_fire;
    end

    // Next-state: arbitration and request capture in IDLE, completion in BUSY
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        grant_nxt     = o_grant;
        count_nxt     = count;
        s_bus_en_nxt  = o_s_bus_en;
        s_wr_en_nxt   = o_s_wr_en;
        s_wr_data_nxt = o_s_wr_data;
        s_addr_nxt    = o_s_addr;
        s_byte_en_nxt = o_s_byte_en;
        sel           = (i_m0_bus_en && i_m1_bus_en) ? ptr : i_m1_bus_en;
        case (state)
            IDLE: begin
                if (i_m0_bus_en || i_m1_bus_en) begin
                    state_nxt     = BUSY;
                    grant_nxt     = sel;
                    count_nxt     = '0;
                    s_bus_en_nxt  = 1'b1;
                    s_wr_en_nxt   = sel ? i_m1_wr_en   : i_m0_wr_en;
                    s_wr_data_nxt = sel ? i_m1_wr_data : i_m0_wr_data;
                    s_addr_nxt    = sel ? i_m1_addr    : i_m0_addr;
                    s_byte_en_nxt = sel ? i_m1_byte_en : i_m0_byte_en;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt    = IDLE;
                    s_bus_en_nxt = 1'b0;
                    ptr_nxt      = ~o_grant;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                s_bus_en_nxt = 1'b0;
            end
        endcase
    end

    // State and slave-side request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            o_grant     <= 1'b0;
            count       <= '0;
            o_s_bus_en  <= 1'b0;
            o_s_wr_en   <= 1'b0;
            o_s_wr_data <= 32'h0000_0000;
            o_s_addr    <= 32'h0000_0000;
            o_s_byte_en <= 4'h0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            o_grant     <= grant_nxt;
            count       <= count_nxt;
            o_s_bus_en  <= s_bus_en_nxt;
            o_s_wr_en   <= s_wr_en_nxt;
            o_s_wr_data <= s_wr_data_nxt;
            o_s_addr    <= s_addr_nxt;
            o_s_byte_en <= s_byte_en_nxt;
        end
    end

endmodule

// File: tb/tb_arvi_bus_arbiter.sv
// Directed bench for arvi_bus_arbiter: read, contention, fairness, write
// capture, watchdog and reset abort, with hand-computed expectations.
module tb_arvi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_bus_en = 1'b0, m0_wr_en = 1'b0;
    logic [31:0] m0_wr_data = 32'h0, m0_addr = 32'h0;
    logic [3:0]  m0_byte_en = 4'h0;
    logic        m0_ack;
    logic [31:0] m0_rd_data;
    logic        m1_bus_en = 1'b0, m1_wr_en = 1'b0;
    logic [31:0] m1_wr_data = 32'h0, m1_addr = 32'h0;
    logic [3:0]  m1_byte_en = 4'h0;
    logic        m1_ack;
    logic [31:0] m1_rd_data;
    logic        s_bus_en, s_wr_en;
    logic [31:0] s_wr_data, s_addr;
    logic [3:0]  s_byte_en;
    logic        s_ack = 1'b0;
    logic [31:0] s_rd_data = 32'h0;
    logic        grant, timeout;

    int passed = 0;
    int total  = 0;

    arvi_bus_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .i_m0_bus_en(m0_bus_en), .i_m0_wr_en(m0_wr_en), .i_m0_wr_data(m0_wr_data),
        .i_m0_addr(m0_addr), .i_m0_byte_en(m0_byte_en),
        .o_m0_ack(m0_ack), .o_m0_rd_data(m0_rd_data),
        .i_m1_bus_en(m1_bus_en), .i_m1_wr_en(m1_wr_en), .i_m1_wr_data(m1_wr_data),
        .i_m1_addr(m1_addr), .i_m1_byte_en(m1_byte_en),
        .o_m1_ack(m1_ack), .o_m1_rd_data(m1_rd_data),
        .o_s_bus_en(s_bus_en), .o_s_wr_en(s_wr_en), .o_s_wr_data(s_wr_data),
        .o_s_addr(s_addr), .o_s_byte_en(s_byte_en),
        .i_s_ack(s_ack), .i_s_rd_data(s_rd_data),
        .o_grant(grant), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_s_bus_en", 32'(s_bus_en), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        step();
        rst = 1'b0;
        step();

        // single read, slave acks two cycles after request reaches it
        m0_bus_en = 1'b1; m0_addr = 32'h0000_0100; m0_wr_en = 1'b0; m0_byte_en = 4'hF;
        step();
        chk("rd_s_bus_en", 32'(s_bus_en), 32'd1);
        chk("rd_s_addr", s_addr, 32'h0000_0100);
        chk("rd_s_wr_en", 32'(s_wr_en), 32'd0);
        chk("rd_ack_early0", 32'(m0_ack), 32'd0);
        step();
        chk("rd_ack_early1", 32'(m0_ack), 32'd0);
        step();
        s_ack = 1'b1; s_rd_data = 32'h1234_5678;
        #1;
        chk("rd_m0_ack", 32'(m0_ack), 32'd1);
        chk("rd_m0_data", m0_rd_data, 32'h1234_5678);
        chk("rd_m1_ack", 32'(m1_ack), 32'd0);
        chk("rd_m1_data", m1_rd_data, 32'd0);
        step();
        m0_bus_en = 1'b0; s_ack = 1'b0;
        #1;
        chk("rd_idle_bus_en", 32'(s_bus_en), 32'd0);
        chk("rd_idle_ack", 32'(m0_ack), 32'd0);
        step();

        // contention from reset with an immediately acking slave
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_bus_en = 1'b1; m0_addr = 32'h0000_0A00;
        m1_bus_en = 1'b1; m1_addr = 32'h0000_0B00; m1_wr_en = 1'b0; m1_byte_en = 4'hF;
        s_ack = 1'b1; s_rd_data = 32'h0000_1111;
        step();
        chk("ct_grant0", 32'(grant), 32'd0);
        chk("ct_addr0", s_addr, 32'h0000_0A00);
        chk("ct_acks0", {30'd0, m1_ack, m0_ack}, 32'd1);
        m0_bus_en = 1'b0;
        step();
        chk("ct_idle_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        step();
        chk("ct_grant1", 32'(grant), 32'd1);
        chk("ct_addr1", s_addr, 32'h0000_0B00);
        chk("ct_acks1", {30'd0, m1_ack, m0_ack}, 32'd2);
        m1_bus_en = 1'b0;
        step();
        chk("ct_grant_hold", 32'(grant), 32'd1);
        chk("ct_bus_en_off", 32'(s_bus_en), 32'd0);

        // fairness: both masters pending in every IDLE cycle
        m0_bus_en = 1'b1; m1_bus_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("fair_grant%0d", i), 32'(grant), 32'(i % 2));
            chk($sformatf("fair_ack%0d", i), {30'd0, m1_ack, m0_ack}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i % 2 == 0) m0_bus_en = 1'b0; else m1_bus_en = 1'b0;
            step();
            if (i % 2 == 0) m0_bus_en = 1'b1; else m1_bus_en = 1'b1;
        end
        m0_bus_en = 1'b0; m1_bus_en = 1'b0; s_ack = 1'b0;
        step();

        // write capture stays fixed while the master changes its inputs
        m1_bus_en = 1'b1; m1_wr_en = 1'b1; m1_wr_data = 32'hCAFE_BABE;
        m1_addr = 32'h0000_2000; m1_byte_en = 4'b0011;
        step();
        chk("wr_grant", 32'(grant), 32'd1);
        m1_wr_en = 1'b0; m1_wr_data = 32'h0; m1_addr = 32'h0000_3000; m1_byte_en = 4'hF;
        step();
        step();
        chk("wr_s_wr_en", 32'(s_wr_en), 32'd1);
        chk("wr_s_data", s_wr_data, 32'hCAFE_BABE);
        chk("wr_s_addr", s_addr, 32'h0000_2000);
        chk("wr_s_be", 32'(s_byte_en), 32'h3);
        chk("wr_s_bus_en", 32'(s_bus_en), 32'd1);
        s_ack = 1'b1;
        #1;
        chk("wr_acks", {30'd0, m1_ack, m0_ack}, 32'd2);
        step();
        m1_bus_en = 1'b0; s_ack = 1'b0;
        step();

        // watchdog: slave silent, fires in the fourth BUSY cycle
        m0_bus_en = 1'b1; m0_addr = 32'h0000_0400; m0_wr_en = 1'b0;
        step();
        chk("wd_c1_timeout", 32'(timeout), 32'd0);
        step();
        step();
        chk("wd_c3_ack", 32'(m0_ack), 32'd0);
        chk("wd_c3_timeout", 32'(timeout), 32'd0);
        step();
        chk("wd_c4_ack", 32'(m0_ack), 32'd1);
        chk("wd_c4_timeout", 32'(timeout), 32'd1);
        chk("wd_c4_data", m0_rd_data, 32'hDEAD_BEEF);
        chk("wd_c4_m1_ack", 32'(m1_ack), 32'd0);
        m0_bus_en = 1'b0;
        step();
        chk("wd_idle_timeout", 32'(timeout), 32'd0);
        chk("wd_idle_bus_en", 32'(s_bus_en), 32'd0);
        s_ack = 1'b1; s_rd_data = 32'h0000_0BAD;
        #1;
        chk("wd_late_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        s_ack = 1'b0;
        step();

        // real ack on the watchdog cycle wins
        m1_bus_en = 1'b1; m1_wr_en = 1'b0; m1_addr = 32'h0000_0500;
        step();
        step();
        step();
        step();
        s_ack = 1'b1; s_rd_data = 32'h55AA_55AA;
        #1;
        chk("race_ack", 32'(m1_ack), 32'd1);
        chk("race_data", m1_rd_data, 32'h55AA_55AA);
        chk("race_timeout", 32'(timeout), 32'd0);
        step();
        m1_bus_en = 1'b0; s_ack = 1'b0;
        step();

        // reset mid-transaction
        m0_bus_en = 1'b1; m0_addr = 32'h0000_0600;
        step();
        chk("ra_busy", 32'(s_bus_en), 32'd1);
        s_ack = 1'b1; s_rd_data = 32'h0000_0777;
        rst = 1'b1;
        #1;
        chk("ra_bus_en", 32'(s_bus_en), 32'd0);
        chk("ra_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("ra_addr", s_addr, 32'd0);
        m0_bus_en = 1'b0; s_ack = 1'b0;
        step();
        rst = 1'b0;
        m1_bus_en = 1'b1; m1_addr = 32'h0000_0800;
        step();
        chk("ra_m1_grant", 32'(grant), 32'd1);
        chk("ra_m1_bus_en", 32'(s_bus_en), 32'd1);
        chk("ra_m1_addr", s_addr, 32'h0000_0800);
        s_ack = 1'b1; s_rd_data = 32'h0000_0999;
        #1;
        chk("ra_m1_ack", {30'd0, m1_ack, m0_ack}, 32'd2);
        step();
        m1_bus_en = 1'b0; s_ack = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
